// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory: clear sweep, program load mode, 1-cycle fetch.
// Optional macro IMEM_ADDR_CHECK_EN flags misaligned or out-of-range fetches.
module instr_mem_sync #(
    parameter int          ADDR_WIDTH  = 8,
    parameter logic [31:0] RESET_INSTR = 32'h00000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    output logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [31:0]           fetch_instr,
    output logic                  fetch_err,
    input  logic                  load_mode,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [31:0]           prog_data,
    input  logic                  clear_start,
    output logic [1:0]            state_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = '1;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] sweep_cnt;
    logic [31:0]           mem [DEPTH];
    logic                  accept;
    logic [ADDR_WIDTH-1:0] widx;
    logic [31:0]           rd_data;

    assign fetch_ready = (state == RUN);
    assign accept      = fetch_req & fetch_ready;
    assign widx        = fetch_addr[ADDR_WIDTH+1:2];
    assign state_o     = state;

`ifdef IMEM_ADDR_CHECK_EN
    logic addr_bad;
    logic err_q;

    assign addr_bad = (|fetch_addr[1:0]) | (|fetch_addr[31:ADDR_WIDTH+2]);
    assign rd_data  = addr_bad ? RESET_INSTR : mem[widx];
    assign fetch_err = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= addr_bad;
        end
    end
`else
    // Low and high address bits wrap silently in this build.
    logic unused_addr_bits;

    assign unused_addr_bits = ^{fetch_addr[31:ADDR_WIDTH+2], fetch_addr[1:0]};
    assign rd_data   = mem[widx];
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= CLEAR;
            sweep_cnt   <= '0;
            fetch_valid <= 1'b0;
            fetch_instr <= RESET_INSTR;
        end else begin
            fetch_valid <= accept;
            if (accept) begin
                fetch_instr <= rd_data;
            end
            unique case (state)
                CLEAR: begin
                    sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
                    if (sweep_cnt == LAST) begin
                        state <= load_mode ? LOAD : RUN;
                    end
                end
                RUN: begin
                    if (clear_start) begin
                        state     <= CLEAR;
                        sweep_cnt <= '0;
                    end else if (load_mode) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (clear_start) begin
                        state     <= CLEAR;
                        sweep_cnt <= '0;
                    end else if (!load_mode) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state     <= CLEAR;
                    sweep_cnt <= '0;
                end
            endcase
        end
    end

    // Storage is never reset; the sweep is what initialises it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[sweep_cnt] <= RESET_INSTR;
        end else if (state == LOAD && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

endmodule

// File: doc/instr_mem_sync.md
INSTR_MEM_SYNC -- requirements
Module: instr_mem_sync

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning word-address bits; DEPTH = 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter RESET_INSTR, default 32'h00000000, meaning the fill/NOP word.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, meaning asynchronous active-high reset.
REQ-006 SHALL have port fetch_req, input, 1 bit, meaning fetch request.
REQ-007 SHALL have port fetch_addr, input, 32 bits, meaning byte address.
REQ-008 SHALL have port fetch_ready, output, 1 bit, meaning a fetch is accepted this cycle.
REQ-009 SHALL have port fetch_valid, output, 1 bit, meaning fetch_instr/fetch_err are valid.
REQ-010 SHALL have port fetch_instr, output, 32 bits, meaning the fetched instruction.
REQ-011 SHALL have port fetch_err, output, 1 bit, meaning address fault.
REQ-012 SHALL have port load_mode, input, 1 bit, meaning request programming mode.
REQ-013 SHALL have port prog_we, input, 1 bit, meaning write strobe.
REQ-014 SHALL have port prog_addr, input, ADDR_WIDTH bits, meaning word address.
REQ-015 SHALL have port prog_data, input, 32 bits, meaning write data.
REQ-016 SHALL have port clear_start, input, 1 bit, meaning a pulse that restarts the clear sweep.
REQ-017 SHALL have port state_o, output, 2 bits, meaning the current state: CLEAR=0, RUN=1, LOAD=2.

Function
REQ-018 SHALL implement an FSM with states CLEAR, RUN and LOAD.
REQ-019 In CLEAR, SHALL write RESET_INSTR to word sweep_cnt each cycle while sweep_cnt runs 0..DEPTH-1, completing in exactly DEPTH cycles.
REQ-020 At sweep_cnt==DEPTH-1, SHALL go to LOAD if load_mode=1, else to RUN.
REQ-021 In RUN, SHALL go to LOAD when load_mode=1; in LOAD, SHALL go to RUN when load_mode=0.
REQ-022 From RUN or LOAD, clear_start=1 SHALL go to CLEAR with sweep_cnt=0; clear_start SHALL take priority over load_mode; clear_start SHALL be ignored in CLEAR.
REQ-023 fetch_ready SHALL be combinational and equal to (state==RUN).
REQ-024 A fetch SHALL be accepted when fetch_req & fetch_ready; on an accepted fetch at cycle N, fetch_valid=1 with data at cycle N+1 (1-cycle latency), supporting back-to-back fetches every cycle.
REQ-025 fetch_valid SHALL be 0 in any cycle following a non-accepted cycle; fetch_instr and fetch_err SHALL hold their last values while fetch_valid=0.
REQ-026 The word index SHALL be fetch_addr[ADDR_WIDTH+1:2].
REQ-027 prog_we SHALL write prog_data to prog_addr only in LOAD; in RUN and CLEAR, prog_we SHALL be ignored.
REQ-028 A fetch accepted in the cycle in which RUN->LOAD or RUN->CLEAR occurs SHALL still be answered at N+1.

Reset
REQ-029 Reset SHALL asynchronously set state=CLEAR, sweep_cnt=0, fetch_valid=0, fetch_instr=RESET_INSTR and fetch_err=0.
REQ-030 Memory contents SHALL NOT be reset directly; they are initialised by the CLEAR sweep, which begins on the first edge after reset deassertion.
REQ-031 Reset asserted mid-sweep SHALL restart the sweep from 0 after release, with a full DEPTH cycles.

Configuration
REQ-032 With macro IMEM_ADDR_CHECK_EN defined, an accepted fetch whose fetch_addr[1:0]!=0 or which has any bit of fetch_addr[31:ADDR_WIDTH+2] set SHALL return fetch_err=1 and fetch_instr=RESET_INSTR.
REQ-033 With IMEM_ADDR_CHECK_EN undefined, fetch_err SHALL be tied to 0, the low 2 bits and the upper bits SHALL be ignored (wrap-around), and the check logic SHALL be absent.

Verification
REQ-034 With ADDR_WIDTH=4, release reset -> fetch_ready=0 for 16 cycles then 1; a fetch of 0x0C -> next cycle fetch_valid=1 and fetch_instr=0x00000000.
REQ-035 With load_mode=1, write word3=0x201c0000 and word4=0x20080040, then set load_mode=0; fetch 0x0C then 0x10 back-to-back -> two consecutive valid cycles returning 0x201c0000 and 0x20080040.
REQ-036 With the macro defined, fetch 0x0E -> err=1 and instr=0; fetch 0x40 (ADDR_WIDTH=4) -> err=1. With the macro undefined, 0x0E -> word3 and 0x40 -> word0, with err=0.
REQ-037 Pulse clear_start in RUN after loading -> fetch_ready=0 for 16 cycles; a subsequent fetch of 0x0C -> 0x00000000.
REQ-038 Assert reset at sweep_cnt=7 -> fetch_valid=0 immediately; after release, fetch_ready stays 0 for a full 16 cycles.
REQ-039 Raise load_mode in the same cycle as an accepted fetch -> response at N+1; a following fetch_req gives fetch_valid=0, and a prog_we in RUN leaves the word unchanged.
